seg_display_arbiter: RTL and testbench

Shares the Go Board's two-digit 7-segment display between NUM_REQ requesters. Each requester supplies two nibbles and a decoder mode. The block grants the display round-robin, enforces a hold window per grant, and blanks the display for one cycle between owners. When no one is requesting, it drives a spinner animation. Its outputs feed two Binary_To_7Segment decoders, one per digit, which share o_Mode.

---
 rtl/seg_display_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the two-digit 7-segment display, with idle spinner.
// Define DISPLAY_ARB_PREEMPT_EN to let requester 0 preempt other owners.
module seg_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 25000000,
    parameter int SPIN_CYCLES = 2500000
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Data,
    input  logic [2*NUM_REQ-1:0]   i_Mode,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic [NUM_REQ-1:0]     o_Done,
    output logic                   o_Active,
    output logic [3:0]             o_Digit1_Num,
    output logic [3:0]             o_Digit2_Num,
    output logic [1:0]             o_Mode
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(SPIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic              active_q, active_d;
    logic [3:0]        d1_q, d1_d, d2_q, d2_d;
    logic [1:0]        mode_q, mode_d;
    logic [IW-1:0]     ptr_q, ptr_d, own_q, own_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [SW-1:0]     spin_q, spin_d;
    logic [3:0]        sidx_q, sidx_d;

    logic [7:0]        data_arr [NUM_REQ];
    logic [1:0]        mode_arr [NUM_REQ];
    logic [IW-1:0]     win, jj, own_nxt;
    logic              found, take, preempt, timeout, drop;
    int                j;

`ifdef DISPLAY_ARB_PREEMPT_EN
    logic pre_q, pre_d;
    assign preempt = i_Req[0] && (own_q != '0);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            data_arr[k] = i_Data[8*k +: 8];
            mode_arr[k] = i_Mode[2*k +: 2];
        end
    end

    // First request at or above the pointer, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IW'(j);
            if (!found && i_Req[jj]) begin
                win   = jj;
                found = 1'b1;
            end
        end
`ifdef DISPLAY_ARB_PREEMPT_EN
        if (state_q == RELEASE && pre_q && i_Req[0]) win = '0;
`endif
    end

    assign own_nxt = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
    assign timeout = (hold_q == HW'(HOLD_CYCLES - 1));
    assign drop    = !i_Req[own_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        active_d = active_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        mode_d   = mode_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        hold_d   = hold_q;
        spin_d   = spin_q;
        sidx_d   = sidx_q;
        take     = 1'b0;
`ifdef DISPLAY_ARB_PREEMPT_EN
        pre_d    = pre_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    take = 1'b1;
                end else begin
                    if (spin_q == SW'(SPIN_CYCLES - 1)) begin
                        spin_d = '0;
                        sidx_d = (sidx_q == 4'd11) ? 4'd0 : sidx_q + 4'd1;
                    end else begin
                        spin_d = spin_q + 1'b1;
                    end
                    mode_d = 2'b11;
                    d1_d   = sidx_d;
                    d2_d   = sidx_d;
                end
            end
            OWN: begin
                hold_d = hold_q + 1'b1;
                d1_d   = data_arr[own_q][7:4];
                d2_d   = data_arr[own_q][3:0];
                mode_d = mode_arr[own_q];
                if (timeout || drop || preempt) begin
                    state_d        = RELEASE;
                    grant_d        = '0;
                    active_d       = 1'b0;
                    done_d[own_q]  = 1'b1;
                    mode_d         = 2'b01;
                    d1_d           = 4'hF;
                    d2_d           = 4'hF;
                    hold_d         = '0;
                    ptr_d          = preempt ? own_q : own_nxt;
`ifdef DISPLAY_ARB_PREEMPT_EN
                    pre_d          = preempt;
`endif
                end
            end
            RELEASE: begin
                if (found) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                    mode_d  = 2'b11;
                    d1_d    = 4'h0;
                    d2_d    = 4'h0;
                    spin_d  = '0;
                    sidx_d  = 4'h0;
`ifdef DISPLAY_ARB_PREEMPT_EN
                    pre_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d      = OWN;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            active_d     = 1'b1;
            own_d        = win;
            hold_d       = '0;
            spin_d       = '0;
            sidx_d       = 4'h0;
            d1_d         = data_arr[win][7:4];
            d2_d         = data_arr[win][3:0];
            mode_d       = mode_arr[win];
`ifdef DISPLAY_ARB_PREEMPT_EN
            pre_d        = 1'b0;
`endif
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            active_q <= 1'b0;
            d1_q     <= 4'h0;
            d2_q     <= 4'h0;
            mode_q   <= 2'b11;
            ptr_q    <= '0;
            own_q    <= '0;
            hold_q   <= '0;
            spin_q   <= '0;
            sidx_q   <= 4'h0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            active_q <= active_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            mode_q   <= mode_d;
            ptr_q    <= ptr_d;
            own_q    <= own_d;
            hold_q   <= hold_d;
            spin_q   <= spin_d;
            sidx_q   <= sidx_d;
        end
    end

`ifdef DISPLAY_ARB_PREEMPT_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) pre_q <= 1'b0;
        else         pre_q <= pre_d;
    end
`endif

    assign o_Grant      = grant_q;
    assign o_Done       = done_q;
    assign o_Active     = active_q;
    assign o_Digit1_Num = d1_q;
    assign o_Digit2_Num = d2_q;
    assign o_Mode       = mode_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with short hold/spin periods.
module tb_seg_display_arbiter;
    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic [3:0]  i_Req;
    logic [31:0] i_Data;
    logic [7:0]  i_Mode;
    logic [3:0]  o_Grant, o_Done;
    logic        o_Active;
    logic [3:0]  o_Digit1_Num, o_Digit2_Num;
    logic [1:0]  o_Mode;

    int n_cmp = 0;
    int n_bad = 0;

    seg_display_arbiter #(
        .NUM_REQ(4), .HOLD_CYCLES(8), .SPIN_CYCLES(4)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Req(i_Req),
        .i_Data(i_Data), .i_Mode(i_Mode), .o_Grant(o_Grant),
        .o_Done(o_Done), .o_Active(o_Active),
        .o_Digit1_Num(o_Digit1_Num), .o_Digit2_Num(o_Digit2_Num),
        .o_Mode(o_Mode)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [3:0] g,
                              input logic [3:0] d, input logic a,
                              input logic [3:0] n1, input logic [3:0] n2,
                              input logic [1:0] m);
        chk({tag, "_grant"}, 32'(o_Grant), 32'(g));
        chk({tag, "_done"}, 32'(o_Done), 32'(d));
        chk({tag, "_active"}, 32'(o_Active), 32'(a));
        chk({tag, "_d1"}, 32'(o_Digit1_Num), 32'(n1));
        chk({tag, "_d2"}, 32'(o_Digit2_Num), 32'(n2));
        chk({tag, "_mode"}, 32'(o_Mode), 32'(m));
    endtask

    // One full round-robin slot: grant, 8 owned cycles, one blank cycle.
    task automatic slot(input int k, input logic [7:0] dv,
                        input logic [1:0] mv);
        logic [3:0] oh;
        oh = 4'(1 << k);
        tick();
        expect_all("rr_grant", oh, 4'h0, 1'b1, dv[7:4], dv[3:0], mv);
        repeat (7) tick();
        chk("rr_hold_grant", 32'(o_Grant), 32'(oh));
        tick();
        expect_all("rr_rel", 4'h0, oh, 1'b0, 4'hF, 4'hF, 2'b01);
    endtask

    initial begin
        i_Reset = 1'b1;
        i_Req   = 4'h0;
        i_Data  = 32'h0;
        i_Mode  = 8'h0;
        tick();
        tick();
        i_Reset = 1'b0;
        expect_all("reset", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b11);

        for (int t = 1; t <= 52; t++) begin
            tick();
            chk("spin_d1", 32'(o_Digit1_Num), 32'((t / 4) % 12));
            chk("spin_d2", 32'(o_Digit2_Num), 32'((t / 4) % 12));
        end
        chk("spin_mode", 32'(o_Mode), 32'h3);
        chk("spin_grant", 32'(o_Grant), 32'h0);

        i_Data[15:8] = 8'h42;
        i_Mode[3:2]  = 2'b00;
        i_Req        = 4'b0010;
        tick();
        expect_all("one_grant", 4'b0010, 4'h0, 1'b1, 4'h4, 4'h2, 2'b00);
        tick();
        i_Req = 4'b1010;
        tick();
        chk("ignore_other", 32'(o_Grant), 32'h2);
        i_Req = 4'b0010;
        repeat (5) tick();
        expect_all("one_last", 4'b0010, 4'h0, 1'b1, 4'h4, 4'h2, 2'b00);
        tick();
        expect_all("one_rel", 4'h0, 4'b0010, 1'b0, 4'hF, 4'hF, 2'b01);
        tick();
        expect_all("one_regrant", 4'b0010, 4'h0, 1'b1, 4'h4, 4'h2, 2'b00);
        tick();
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        expect_all("mid_reset", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b11);

        i_Data = 32'h43_32_21_10;
        i_Mode = 8'b11_10_01_00;
        i_Req  = 4'b1011;
        slot(0, 8'h10, 2'd0);
        slot(1, 8'h21, 2'd1);
        slot(3, 8'h43, 2'd3);
        tick();
        expect_all("rr_wrap", 4'b0001, 4'h0, 1'b1, 4'h1, 4'h0, 2'd0);
        repeat (7) tick();
        i_Req = 4'h0;
        tick();
        expect_all("both_rel", 4'h0, 4'b0001, 1'b0, 4'hF, 4'hF, 2'b01);
        tick();
        expect_all("both_idle", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b11);

        i_Req = 4'b0100;
        tick();
        expect_all("drop_grant", 4'b0100, 4'h0, 1'b1, 4'h3, 4'h2, 2'd2);
        i_Data[23:16] = 8'h5A;
        tick();
        expect_all("live_data", 4'b0100, 4'h0, 1'b1, 4'h5, 4'hA, 2'd2);
        i_Req = 4'h0;
        tick();
        expect_all("drop_rel", 4'h0, 4'b0100, 1'b0, 4'hF, 4'hF, 2'b01);
        tick();
        expect_all("drop_idle", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b11);
        repeat (3) tick();
        chk("spin_restart0", 32'(o_Digit1_Num), 32'h0);
        tick();
        chk("spin_restart1", 32'(o_Digit1_Num), 32'h1);

`ifdef DISPLAY_ARB_PREEMPT_EN
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        i_Req = 4'b0100;
        tick();
        chk("pre_own2", 32'(o_Grant), 32'h4);
        i_Req = 4'b1101;
        tick();
        expect_all("pre_rel", 4'h0, 4'b0100, 1'b0, 4'hF, 4'hF, 2'b01);
        tick();
        expect_all("pre_grant0", 4'b0001, 4'h0, 1'b1, 4'h1, 4'h0, 2'd0);
        i_Req = 4'b1100;
        tick();
        chk("pre_done0", 32'(o_Done), 32'h1);
        tick();
        chk("pre_back2", 32'(o_Grant), 32'h4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
